// File: rtl/pc_shooter.sv
// PC opponent shot engine: picks a player-board cell with an LFSR, falls back to a
// row-major scan after MAX_TRIES rejected candidates, then marks the cell hit or miss.
module pc_shooter #(
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter int unsigned MAX_TRIES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pc_turn_State,
  input  logic [2:0] player_ship_amount_define,
  output logic [2:0] rd_i,
  output logic [2:0] rd_j,
  input  logic [1:0] rd_data,
  output logic       wr_en,
  output logic [2:0] wr_i,
  output logic [2:0] wr_j,
  output logic [1:0] wr_data,
  output logic       shot_done,
  output logic       shot_hit,
  output logic [2:0] shot_i,
  output logic [2:0] shot_j,
  output logic       no_target,
  output logic [2:0] hits_count,
  output logic       all_sunk
);

  localparam int unsigned TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);

  typedef enum logic [2:0] {IDLE, PICK, SCAN, WRITE, DONE} state_t;

  state_t        state_q;
  logic [7:0]    lfsr_q, lfsr_d;
  logic          turn_q;
  logic [TW-1:0] try_q;
  logic [2:0]    scan_i_q, scan_j_q;
  logic          wr_en_q, shot_done_q, shot_hit_q, no_target_q;
  logic [2:0]    wr_i_q, wr_j_q, shot_i_q, shot_j_q, hits_count_q;
  logic [1:0]    wr_data_q;

  logic [2:0] cand_i, cand_j, sel_i, sel_j;
  logic       cell_ok, cell_ship, pick_ok, accept, scan_last;

  assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign cand_i    = lfsr_q[2:0];
  assign cand_j    = lfsr_q[5:3];
  assign cell_ok   = ~rd_data[1];
  assign cell_ship = (rd_data == 2'b01);
  assign pick_ok   = (cand_i <= 3'd4) && (cand_j <= 3'd4) && cell_ok;
  assign scan_last = (scan_i_q == 3'd4) && (scan_j_q == 3'd4);
  assign sel_i     = (state_q == PICK) ? cand_i : scan_i_q;
  assign sel_j     = (state_q == PICK) ? cand_j : scan_j_q;
  assign accept    = pc_turn_State &&
                     (((state_q == PICK) && pick_ok) || ((state_q == SCAN) && cell_ok));

  always_comb begin
    rd_i = '0;
    rd_j = '0;
    if (state_q == PICK || state_q == SCAN) begin
      rd_i = sel_i;
      rd_j = sel_j;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_SEED;
      turn_q       <= 1'b0;
      try_q        <= '0;
      scan_i_q     <= '0;
      scan_j_q     <= '0;
      wr_en_q      <= 1'b0;
      wr_i_q       <= '0;
      wr_j_q       <= '0;
      wr_data_q    <= '0;
      shot_done_q  <= 1'b0;
      shot_hit_q   <= 1'b0;
      shot_i_q     <= '0;
      shot_j_q     <= '0;
      no_target_q  <= 1'b0;
      hits_count_q <= '0;
    end else begin
      lfsr_q      <= lfsr_d;
      turn_q      <= pc_turn_State;
      // Strobes default low so each is a single-cycle pulse.
      wr_en_q     <= 1'b0;
      wr_i_q      <= '0;
      wr_j_q      <= '0;
      wr_data_q   <= '0;
      shot_done_q <= 1'b0;
      no_target_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pc_turn_State && !turn_q) begin
            state_q  <= PICK;
            try_q    <= '0;
            scan_i_q <= '0;
            scan_j_q <= '0;
          end
        end
        PICK, SCAN: begin
          if (!pc_turn_State) begin
            state_q <= IDLE;
          end else if (accept) begin
            state_q    <= WRITE;
            wr_en_q    <= 1'b1;
            wr_i_q     <= sel_i;
            wr_j_q     <= sel_j;
            wr_data_q  <= cell_ship ? 2'b11 : 2'b10;
            shot_i_q   <= sel_i;
            shot_j_q   <= sel_j;
            shot_hit_q <= cell_ship;
            if (cell_ship && hits_count_q != 3'd7)
              hits_count_q <= hits_count_q + 3'd1;
          end else if (state_q == PICK) begin
            if (try_q == TRY_LAST) state_q <= SCAN;
            else                   try_q   <= try_q + TW'(1);
          end else if (scan_last) begin
            state_q     <= DONE;
            shot_done_q <= 1'b1;
            no_target_q <= 1'b1;
          end else if (scan_j_q == 3'd4) begin
            scan_j_q <= '0;
            scan_i_q <= scan_i_q + 3'd1;
          end else begin
            scan_j_q <= scan_j_q + 3'd1;
          end
        end
        WRITE: begin
          state_q     <= DONE;
          shot_done_q <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_i       = wr_i_q;
  assign wr_j       = wr_j_q;
  assign wr_data    = wr_data_q;
  assign shot_done  = shot_done_q;
  assign shot_hit   = shot_hit_q;
  assign shot_i     = shot_i_q;
  assign shot_j     = shot_j_q;
  assign no_target  = no_target_q;
  assign hits_count = hits_count_q;
  assign all_sunk   = (player_ship_amount_define != 3'd0) &&
                      (hits_count_q >= player_ship_amount_define);

endmodule

// File: tb/tb_pc_shooter.sv
// Scoreboard bench for pc_shooter: stimulus queues expected turn results, a negedge
// monitor checks every write and every shot_done against a player-board model.
module tb_pc_shooter;
  localparam int unsigned MAX_TRIES = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pc_turn_State = 1'b0;
  logic [2:0] player_ship_amount_define = 3'd1;
  logic [2:0] rd_i, rd_j, wr_i, wr_j, shot_i, shot_j, hits_count;
  logic [1:0] rd_data, wr_data;
  logic       wr_en, shot_done, shot_hit, no_target, all_sunk;

  pc_shooter #(.LFSR_SEED(8'hA5), .MAX_TRIES(MAX_TRIES)) dut (
    .clk(clk), .rst(rst), .pc_turn_State(pc_turn_State),
    .player_ship_amount_define(player_ship_amount_define),
    .rd_i(rd_i), .rd_j(rd_j), .rd_data(rd_data),
    .wr_en(wr_en), .wr_i(wr_i), .wr_j(wr_j), .wr_data(wr_data),
    .shot_done(shot_done), .shot_hit(shot_hit), .shot_i(shot_i), .shot_j(shot_j),
    .no_target(no_target), .hits_count(hits_count), .all_sunk(all_sunk)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit chk_coord;
    int i;
    int j;
    bit hit;
    bit nt;
  } exp_t;

  exp_t       q[$];
  logic [1:0] board [5][5];
  int checks = 0, passes = 0;
  int wr_cnt = 0, done_cnt = 0, viol = 0;
  bit prev_wr_en = 0;
  int prev_wr_i = 0, prev_wr_j = 0;

  always_comb begin
    rd_data = 2'b10;
    if (rd_i < 3'd5 && rd_j < 3'd5) rd_data = board[rd_i][rd_j];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: checks writes against the board model and pops the scoreboard on shot_done.
  always @(negedge clk) begin
    if (rst) begin
      prev_wr_en = 0;
    end else begin
      if (wr_en) begin
        wr_cnt++;
        chk("wr_in_range", {30'd0, wr_i < 3'd5, wr_j < 3'd5}, 32'd3);
        if (wr_i < 3'd5 && wr_j < 3'd5) begin
          chk("wr_target_unshot", {31'd0, board[wr_i][wr_j][1]}, 32'd0);
          chk("wr_data", {30'd0, wr_data},
              (board[wr_i][wr_j] == 2'b01) ? 32'd3 : 32'd2);
          board[wr_i][wr_j] = wr_data;
        end
      end else if (wr_i != 3'd0 || wr_j != 3'd0 || wr_data != 2'd0) begin
        viol++;
      end
      if (no_target && !shot_done) viol++;
      if (shot_done) begin
        done_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_shot_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("no_target", {31'd0, no_target}, {31'd0, e.nt});
          chk("write_before_done", {31'd0, prev_wr_en}, {31'd0, !e.nt});
          if (!e.nt) begin
            chk("shot_hit", {31'd0, shot_hit}, {31'd0, e.hit});
            chk("shot_i_matches_write", {29'd0, shot_i}, prev_wr_i);
            chk("shot_j_matches_write", {29'd0, shot_j}, prev_wr_j);
            if (e.chk_coord) chk("shot_coord", {26'd0, shot_i, shot_j},
                                 32'(e.i * 8 + e.j));
          end
        end
      end
      prev_wr_en = wr_en;
      prev_wr_i  = int'(wr_i);
      prev_wr_j  = int'(wr_j);
    end
  end

  task automatic fill_board(input logic [1:0] v);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) board[i][j] = v;
  endtask

  task automatic rst_pulse();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic request(input exp_t e, output int cyc);
    int start;
    start = done_cnt;
    q.push_back(e);
    pc_turn_State = 1'b1;
    cyc = 0;
    while (done_cnt == start && cyc < int'(MAX_TRIES) + 32) begin
      @(posedge clk);
      cyc++;
    end
    if (done_cnt == start) begin
      chk("shot_timeout", 32'd0, 32'd1);
      void'(q.pop_back());
    end
    @(negedge clk) pc_turn_State = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic exp_t mk(bit c, int i, int j, bit hit, bit nt);
    exp_t e;
    e.chk_coord = c; e.i = i; e.j = j; e.hit = hit; e.nt = nt;
    return e;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, w0, d0, n;
    fill_board(2'b10);

    // Reset state.
    #12;
    chk("reset_outputs", {9'd0, wr_en, wr_i, wr_j, wr_data, shot_done, shot_hit, shot_i,
                          shot_j, no_target, hits_count, all_sunk, rd_i, rd_j}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    // Single ship cell at (2,3).
    board[2][3] = 2'b01;
    request(mk(1, 2, 3, 1, 0), cyc);
    chk("t1_hits_count", {29'd0, hits_count}, 32'd1);
    chk("t1_all_sunk", {31'd0, all_sunk}, 32'd1);
    chk("t1_write_count", wr_cnt, 32'd1);
    chk("t1_board_23", {30'd0, board[2][3]}, 32'd3);

    // Async reset in the middle of PICK.
    fill_board(2'b10);
    w0 = wr_cnt; d0 = done_cnt;
    pc_turn_State = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midpick_reset_outputs", {9'd0, wr_en, wr_i, wr_j, wr_data, shot_done, shot_hit,
                                  shot_i, shot_j, no_target, hits_count, all_sunk, rd_i,
                                  rd_j}, 32'd0);
    pc_turn_State = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("midpick_no_write", wr_cnt - w0, 32'd0);
    chk("midpick_no_done", done_cnt - d0, 32'd0);
    board[0][4] = 2'b01;
    request(mk(1, 0, 4, 1, 0), cyc);
    chk("after_reset_hits", {29'd0, hits_count}, 32'd1);

    // Exhausted board of misses and hits.
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) board[i][j] = ((i + j) % 2 == 0) ? 2'b10 : 2'b11;
    w0 = wr_cnt;
    request(mk(0, 0, 0, 0, 1), cyc);
    chk("exhausted_no_write", wr_cnt - w0, 32'd0);
    chk("exhausted_latency_ok", {31'd0, cyc <= int'(MAX_TRIES) + 28}, 32'd1);

    // Turn dropped two cycles after rising: nothing may be written.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    fill_board(2'b10);
    board[4][4] = 2'b00;
    w0 = wr_cnt; d0 = done_cnt;
    @(negedge clk) pc_turn_State = 1'b1;
    @(negedge clk);
    @(negedge clk) pc_turn_State = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_write", wr_cnt - w0, 32'd0);
    chk("abort_no_done", done_cnt - d0, 32'd0);
    chk("abort_board_44", {30'd0, board[4][4]}, 32'd0);

    // Empty board: 25 distinct misses, then no target.
    rst_pulse();
    player_ship_amount_define = 3'd5;
    fill_board(2'b00);
    w0 = wr_cnt;
    for (int k = 0; k < 25; k++) request(mk(0, 0, 0, 0, 0), cyc);
    n = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) if (board[i][j] == 2'b10) n++;
    chk("empty_all_missed", n, 32'd25);
    chk("empty_write_count", wr_cnt - w0, 32'd25);
    chk("empty_hits_zero", {29'd0, hits_count}, 32'd0);
    request(mk(0, 0, 0, 0, 1), cyc);
    chk("empty_26th_no_write", wr_cnt - w0, 32'd25);

    // Eight hits with five ships: saturation and all_sunk.
    rst_pulse();
    fill_board(2'b10);
    board[0][0] = 2'b01; board[0][2] = 2'b01; board[1][1] = 2'b01; board[1][4] = 2'b01;
    board[2][0] = 2'b01; board[3][3] = 2'b01; board[4][1] = 2'b01; board[4][4] = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      request(mk(0, 0, 0, 1, 0), cyc);
      chk("sat_hits_count", {29'd0, hits_count}, (k > 7) ? 32'd7 : 32'(k));
      chk("sat_all_sunk", {31'd0, all_sunk}, (k >= 5) ? 32'd1 : 32'd0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", q.size(), 32'd0);
    chk("idle_strobe_violations", viol, 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
